// File: rtl/program_mem.sv
// Jac1-8 program ROM: a fixed 64-word instruction image.
// The word addressed by pc is registered onto ir on every rising clock edge.
module program_mem #(
  parameter int PC_WIDTH  = 8,
  parameter int DataWidth = 16,
  parameter int CMD_CNT   = 64
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic [DataWidth-1:0] ir
);

  logic [DataWidth-1:0] rom_word_p0;

  // Addresses at or above CMD_CNT read zero rather than aliasing onto the image.
  function automatic logic [DataWidth-1:0] rom_lookup(input logic [PC_WIDTH-1:0] addr);
    logic [15:0]  word;
    int unsigned  idx;
    word = 16'h0000;
    idx  = 32'(addr);
    if (idx < CMD_CNT) begin
      case (idx)
        0:       word = 16'h4903;
        1:       word = 16'h4A14;
        2:       word = 16'h4BF0;
        3:       word = 16'h0910;
        4:       word = 16'h1918;
        5:       word = 16'h480F;
        6:       word = 16'h2008;
        7:       word = 16'h2918;
        8:       word = 16'h3308;
        9:       word = 16'h1308;
        12:      word = 16'h8008;
        default: word = 16'h0000;
      endcase
    end
    return DataWidth'(word);
  endfunction

  assign rom_word_p0 = rom_lookup(pc);

  // ---- stage p0 -> ir: single output register, no enable ----
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ir <= '0;
    end else begin
      ir <= rom_word_p0;
    end
  end

endmodule

// File: tb/tb_program_mem.sv
// Bench for program_mem: directed scenarios plus randomized fetches and async
// reset pulses, compared against an address-indexed reference image.
module tb_program_mem;

  localparam int PC_WIDTH  = 8;
  localparam int DataWidth = 16;
  localparam int CMD_CNT   = 64;

  logic                 clk;
  logic                 res_n;
  logic [PC_WIDTH-1:0]  pc;
  logic [DataWidth-1:0] ir;

  int n_checks;
  int n_fail;

  program_mem #(
    .PC_WIDTH (PC_WIDTH),
    .DataWidth(DataWidth),
    .CMD_CNT  (CMD_CNT)
  ) dut (
    .clk  (clk),
    .res_n(res_n),
    .pc   (pc),
    .ir   (ir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference program image; everything not listed reads zero.
  function automatic logic [15:0] ref_word(input int addr);
    logic [15:0] image [13];
    image = '{16'h4903, 16'h4A14, 16'h4BF0, 16'h0910, 16'h1918, 16'h480F,
              16'h2008, 16'h2918, 16'h3308, 16'h1308, 16'h0000, 16'h0000,
              16'h8008};
    if (addr < 0 || addr >= CMD_CNT) return 16'h0000;
    if (addr < 13) return image[addr];
    return 16'h0000;
  endfunction

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive pc on the falling edge, then sample just after the next rising edge.
  task automatic fetch(input int addr, input string tag);
    @(negedge clk);
    pc = PC_WIDTH'(addr);
    @(posedge clk);
    #1;
    check_val(tag, ir, ref_word(addr));
  endtask

  initial begin
    logic [15:0] held;
    int          a;
    n_checks = 0;
    n_fail   = 0;
    res_n    = 1'b0;
    pc       = '0;

    #1;
    check_val("reset_initial", ir, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_val("reset_hold", ir, 16'h0000);
    end

    @(negedge clk);
    res_n = 1'b1;
    #1;
    check_val("reset_release_no_edge", ir, 16'h0000);
    @(posedge clk);
    #1;
    check_val("first_fetch", ir, 16'h4903);

    // Latency: change pc mid-cycle, ir must not move until the edge.
    @(negedge clk);
    pc = 8'd1;
    #2;
    check_val("latency_before_edge", ir, 16'h4903);
    @(posedge clk);
    #1;
    check_val("latency_after_edge", ir, 16'h4A14);

    for (int i = 1; i <= 12; i++) fetch(i, "sweep");

    fetch(13, "unused_13");
    fetch(63, "unused_63");
    fetch(64, "oor_64");
    fetch(255, "oor_255");
    fetch(12, "load_8008");

    // Async reset between edges clears ir immediately.
    @(negedge clk);
    res_n = 1'b0;
    #1;
    check_val("async_reset_clear", ir, 16'h0000);
    @(posedge clk);
    #1;
    check_val("async_reset_hold", ir, 16'h0000);
    @(negedge clk);
    res_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("after_async_reset", ir, 16'h8008);

    for (int i = 0; i < 8; i++) fetch((i % 2 == 0) ? 2 : 5, "alternate_2_5");

    fetch(7, "repeat_a");
    fetch(7, "repeat_b");

    // Randomized fetches with occasional mid-cycle reset pulses.
    held = ir;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      check_val("rand_hold", ir, held);
      if ($urandom_range(0, 15) == 0) begin
        res_n = 1'b0;
        #1;
        check_val("rand_async_reset", ir, 16'h0000);
        #1;
        res_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) a = int'($urandom_range(0, 255));
      else a = int'($urandom_range(0, 15));
      pc = PC_WIDTH'(a);
      @(posedge clk);
      #1;
      check_val("rand_fetch", ir, ref_word(a));
      held = ref_word(a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
